// File: rtl/sample_discriminator_pkg.sv
// -----------------------------------------------------------------------------
// sample_discriminator_pkg
//   Shared definitions for the pulse interval meter:
//     DEFAULT_TIMER_BITS - default width of the interval counter and result
//     meter_state_e      - IDLE / MEASURE state encoding of the interval FSM
// -----------------------------------------------------------------------------
package sample_discriminator_pkg;

    localparam int DEFAULT_TIMER_BITS = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

endpackage : sample_discriminator_pkg

// File: rtl/result_holding_reg.sv
// -----------------------------------------------------------------------------
// result_holding_reg
//   One-entry holding register with a valid/ready output handshake. A new
//   result is accepted when the register is empty or is being consumed in the
//   same cycle; otherwise the old result is kept and drop_o pulses next cycle.
//
// Ports
//   clk         : clock
//   reset       : synchronous active-high reset
//   load_i      : a completed result is presented this cycle
//   load_data_i : the completed result
//   ready_i     : consumer accepts data_o this cycle
//   valid_o     : data_o holds an unconsumed result
//   data_o      : held result
//   drop_o      : one-cycle pulse, a result was discarded because we were full
// -----------------------------------------------------------------------------
module result_holding_reg
    import sample_discriminator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_TIMER_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             drop_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             drop_q;
    logic             can_load;

    // Space is available if empty, or if the current entry leaves this cycle.
    assign can_load = !valid_q || ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (load_i) begin
                if (can_load) begin
                    valid_q <= 1'b1;
                    data_q  <= load_data_i;
                end else begin
                    drop_q  <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign drop_o  = drop_q;

endmodule : result_holding_reg

// File: rtl/pulse_interval_meter.sv
// -----------------------------------------------------------------------------
// pulse_interval_meter
//   Measures the number of cycles between a start pulse and a stop pulse.
//   Start sampled in cycle t and stop sampled in cycle t+d+1 reports d.
//   A counter reaching all-ones without a stop abandons the measurement and
//   pulses timeout_pls. Results go through a one-entry holding register.
//
// Parameters
//   TIMER_BITS     : counter / result width
//   RETRIGGER_MODE : 1 = start during a measurement restarts the count
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   start_pls, stop_pls        : interval start / end pulses
//   result_data, result_valid  : measured interval and its valid flag
//   result_ready               : consumer accepts result_data
//   timeout_pls                : measurement abandoned on counter overflow
//   drop_pls                   : completed result discarded (holding reg full)
//   min_interval, max_interval : running extremes of every completed result,
//                                present only when PULSE_INTERVAL_METER_STATS_EN
//                                is defined
// -----------------------------------------------------------------------------
module pulse_interval_meter
    import sample_discriminator_pkg::*;
#(
    parameter int TIMER_BITS     = DEFAULT_TIMER_BITS,
    parameter int RETRIGGER_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_pls,
    input  logic                  stop_pls,
    output logic [TIMER_BITS-1:0] result_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  timeout_pls,
`ifdef PULSE_INTERVAL_METER_STATS_EN
    output logic                  drop_pls,
    output logic [TIMER_BITS-1:0] min_interval,
    output logic [TIMER_BITS-1:0] max_interval
`else
    output logic                  drop_pls
`endif
);

    localparam logic [TIMER_BITS-1:0] COUNT_MAX = '1;

    meter_state_e          state_q;
    logic [TIMER_BITS-1:0] count_q;
    logic                  timeout_q;
    logic                  done;

    // A measurement completes in the cycle stop is seen while measuring; the
    // holding register registers it, so the result appears one cycle later.
    assign done = (state_q == MEASURE) && stop_pls;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A stop coinciding with start belongs to no interval.
                    if (start_pls) begin
                        count_q <= '0;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (stop_pls || (count_q == COUNT_MAX)) begin
                        // Completion or overflow ends this interval; a start in
                        // the same cycle opens the next one immediately.
                        timeout_q <= !stop_pls;
                        count_q   <= '0;
                        if (!start_pls) begin
                            state_q <= IDLE;
                        end
                    end else if (start_pls && (RETRIGGER_MODE != 0)) begin
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign timeout_pls = timeout_q;

    result_holding_reg #(
        .WIDTH (TIMER_BITS)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .load_i      (done),
        .load_data_i (count_q),
        .ready_i     (result_ready),
        .valid_o     (result_valid),
        .data_o      (result_data),
        .drop_o      (drop_pls)
    );

`ifdef PULSE_INTERVAL_METER_STATS_EN
    logic [TIMER_BITS-1:0] min_q;
    logic [TIMER_BITS-1:0] max_q;

    // Extremes track every completed interval, dropped ones included.
    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else if (done) begin
            if (count_q < min_q) begin
                min_q <= count_q;
            end
            if (count_q > max_q) begin
                max_q <= count_q;
            end
        end
    end

    assign min_interval = min_q;
    assign max_interval = max_q;
`endif

endmodule : pulse_interval_meter

// File: doc/pulse_interval_meter.md
PULSE_INTERVAL_METER -- requirements
Module: pulse_interval_meter

Interface
REQ-001 SHALL have parameter TIMER_BITS, default 8, which sets the width of the interval counter and the result.
REQ-002 SHALL have parameter RETRIGGER_MODE, default 0, where 1 means a start pulse during a measurement restarts it.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_pls, input, 1 bit: start-of-interval pulse (the pulse_delay input side).
REQ-006 SHALL have port stop_pls, input, 1 bit: end-of-interval pulse (the pulse_delay output side).
REQ-007 SHALL have port result_data, output, TIMER_BITS bits: measured delay.
REQ-008 SHALL have port result_valid, output, 1 bit: result_data holds an unconsumed result.
REQ-009 SHALL have port result_ready, input, 1 bit: consumer accepts result_data.
REQ-010 SHALL have port timeout_pls, output, 1 bit: one-cycle pulse marking a measurement abandoned on counter overflow.
REQ-011 SHALL have port drop_pls, output, 1 bit: one-cycle pulse marking a completed result discarded because the holding register was full.

Function
REQ-012 SHALL implement two states, IDLE and MEASURE.
REQ-013 SHALL, in IDLE, on start_pls: set counter to 0 and go to MEASURE; a stop_pls in the same cycle is ignored.
REQ-014 SHALL, in IDLE, ignore stop_pls when start_pls is low.
REQ-015 SHALL, in MEASURE, increment the counter by 1 each cycle that stop_pls is low.
REQ-016 SHALL complete a measurement when stop_pls is high in MEASURE, reporting the current counter value, so start at cycle t and stop at cycle t+d+1 gives d, matching pulse_delay delay semantics.
REQ-017 SHALL, on completion with start_pls also high, begin a new measurement (counter=0, stay in MEASURE); otherwise it returns to IDLE.
REQ-018 SHALL, in MEASURE with start_pls high and stop_pls low, ignore start_pls when RETRIGGER_MODE=0 and reset the counter to 0 when RETRIGGER_MODE=1.
REQ-019 SHALL, in MEASURE with counter at 2^TIMER_BITS-1 and stop_pls low, pulse timeout_pls the next cycle, produce no result and go to IDLE (start_pls that cycle obeys REQ-013 instead).
REQ-020 SHALL register a completed result: result_valid and result_data update the cycle after stop_pls is sampled.
REQ-021 SHALL hold result_valid and result_data stable until result_valid and result_ready are both high; the handshake cycle clears result_valid.
REQ-022 SHALL, when a result completes while result_valid is high and result_ready is low, keep the old result and pulse drop_pls the next cycle.
REQ-023 SHALL, when a result completes in a handshake cycle, load the new result (result_valid stays high, no drop).

Reset
REQ-024 SHALL, during reset, force IDLE, counter=0, result_data=0, result_valid=0, timeout_pls=0, drop_pls=0; a measurement in progress is discarded without timeout or drop.
REQ-025 SHALL ignore start_pls and stop_pls in the reset cycle.

Configuration
REQ-026 SHALL, with macro PULSE_INTERVAL_METER_STATS_EN defined, add outputs min_interval and max_interval (TIMER_BITS each) updated from every completed (including dropped) result, reset to all-ones and 0 respectively.
REQ-027 SHALL, without PULSE_INTERVAL_METER_STATS_EN, omit those ports and registers entirely, with all other behaviour identical.

Structure
REQ-028 SHALL place the IDLE/MEASURE state enum and the default TIMER_BITS constant in the shared sample_discriminator package.
REQ-029 SHALL keep the result holding register with its valid/ready and drop logic in one sub-module, result_holding_reg.

Verification
REQ-030 SHALL check that start at t=20 and stop at t=26 gives result_data=5 with result_valid high at t=27.
REQ-031 SHALL check, with result_ready=0 and results 3 then 7, that result_data stays 3 and drop_pls pulses once; after raising result_ready, result_valid clears.
REQ-032 SHALL check, with TIMER_BITS=4 and no stop, that timeout_pls pulses 17 cycles after start and no result is produced.
REQ-033 SHALL check that start at t=0, extra start at t=3 and stop at t=9 gives 8 when RETRIGGER_MODE=0 and 5 when RETRIGGER_MODE=1.
REQ-034 SHALL drive pulse_delay (delay random 1..10, 100 pulses, both retrigger modes) into start_pls/stop_pls and check that every result equals the delay programmed at the start pulse.
REQ-035 SHALL check that asserting reset mid-measurement, then stop, produces no result, timeout or drop.
